// File: rtl/tick_gen_pkg.sv
// Shared constants for the multi-channel game timebase tick generator.
// Optional feature macro: TICK_SQUARE_EN (adds the per-channel square-wave output).
package tick_gen_pkg;

    localparam int TICK_CNT_W_DEF  = 21;
    localparam int TICK_PERIOD_DEF = 500000;

    // Game-rate periods at 50 MHz; 100 ms and 1 s need CNT_W of at least 23 and 26.
    localparam int TICK_PERIOD_10MS  = 500_000;
    localparam int TICK_PERIOD_100MS = 5_000_000;
    localparam int TICK_PERIOD_1S    = 50_000_000;

endpackage

// File: rtl/tick_gen_if.sv
// Control/status bundle for tick_gen: enables, loads, shared period, sync and ticks.
// sq_o only exists when TICK_SQUARE_EN is defined.
interface tick_gen_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = tick_gen_pkg::TICK_CNT_W_DEF
);
    logic [NUM_CH-1:0] en_i;
    logic [NUM_CH-1:0] load_i;
    logic [CNT_W-1:0]  period_i;
    logic              sync_i;
    logic [NUM_CH-1:0] tick_o;
`ifdef TICK_SQUARE_EN
    logic [NUM_CH-1:0] sq_o;
`endif

    modport master (
        output en_i,
        output load_i,
        output period_i,
        output sync_i,
`ifdef TICK_SQUARE_EN
        input  sq_o,
`endif
        input  tick_o
    );

    modport slave (
        input  en_i,
        input  load_i,
        input  period_i,
        input  sync_i,
`ifdef TICK_SQUARE_EN
        output sq_o,
`endif
        output tick_o
    );

endinterface

// File: rtl/tick_chan.sv
// One tick channel: programmable period divider with registered one-cycle tick.
// With TICK_SQUARE_EN a toggle flop turns the tick stream into a 2P square wave.
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int CNT_W          = TICK_CNT_W_DEF,
    parameter int DEFAULT_PERIOD = TICK_PERIOD_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             sync,
    input  logic [CNT_W-1:0] period_new,
    output logic             tick
`ifdef TICK_SQUARE_EN
    ,
    output logic             sq
`endif
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] tc;

    // A programmed period of 0 behaves like 1, so tc never underflows.
    assign tc = (period == '0) ? '0 : period - CNT_W'(1);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            period <= CNT_W'(DEFAULT_PERIOD);
            tick   <= 1'b0;
`ifdef TICK_SQUARE_EN
            sq     <= 1'b0;
`endif
        end else if (load) begin
            period <= period_new;
            cnt    <= '0;
            tick   <= 1'b0;
        end else if (sync) begin
            cnt    <= '0;
            tick   <= 1'b0;
`ifdef TICK_SQUARE_EN
            sq     <= 1'b0;
`endif
        end else if (!en) begin
            tick   <= 1'b0;
        end else if (cnt == tc) begin
            cnt    <= '0;
            tick   <= 1'b1;
`ifdef TICK_SQUARE_EN
            sq     <= ~sq;
`endif
        end else begin
            cnt    <= cnt + CNT_W'(1);
            tick   <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator top: fans shared period/sync out to NUM_CH channels.
// Define TICK_SQUARE_EN to add per-channel square-wave outputs on sq_o.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = TICK_CNT_W_DEF,
    parameter int DEFAULT_PERIOD = TICK_PERIOD_DEF
) (
    input  logic       clk_in,
    input  logic       rst_n,
    tick_gen_if.slave  bus
);

    logic [NUM_CH-1:0] tick_vec;
`ifdef TICK_SQUARE_EN
    logic [NUM_CH-1:0] sq_vec;
    assign bus.sq_o = sq_vec;
`endif

    assign bus.tick_o = tick_vec;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        tick_chan #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_chan (
            .clk_in     (clk_in),
            .rst_n      (rst_n),
            .en         (bus.en_i[k]),
            .load       (bus.load_i[k]),
            .sync       (bus.sync_i),
            .period_new (bus.period_i),
`ifdef TICK_SQUARE_EN
            .sq         (sq_vec[k]),
`endif
            .tick       (tick_vec[k])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: elapsed-edge reference model, directed cases, then random traffic.
// Square-wave checks are active when TICK_SQUARE_EN is defined.
module tb_tick_gen;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int DEF    = 5;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    tick_gen #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] sq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    // Reference model: a channel ticks whenever the number of enabled edges since its
    // last restart (reset, load, sync) is a non-zero multiple of its effective period.
    int                m_period  [NUM_CH];
    int                m_elapsed [NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_sq;

    function automatic void model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_period[k]  = DEF;
            m_elapsed[k] = 0;
        end
        m_tick = '0;
        m_sq   = '0;
    endfunction

    function automatic void model_edge(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] load,
                                       input int per, input logic sync);
        int peff;
        for (int k = 0; k < NUM_CH; k++) begin
            if (load[k]) begin
                m_period[k]  = per % (1 << CNT_W);
                m_elapsed[k] = 0;
                m_tick[k]    = 1'b0;
            end else if (sync) begin
                m_elapsed[k] = 0;
                m_tick[k]    = 1'b0;
                m_sq[k]      = 1'b0;
            end else if (!en[k]) begin
                m_tick[k]    = 1'b0;
            end else begin
                m_elapsed[k] = m_elapsed[k] + 1;
                peff         = (m_period[k] < 1) ? 1 : m_period[k];
                m_tick[k]    = ((m_elapsed[k] % peff) == 0);
                if (m_tick[k]) m_sq[k] = ~m_sq[k];
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.tick = m_tick;
        e.sq   = m_sq;
        exp_q.push_back(e);
    endfunction

    task automatic step(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] load,
                        input int per, input logic sync);
        @(negedge clk_in);
        bus.en_i     = en;
        bus.load_i   = load;
        bus.period_i = CNT_W'(per);
        bus.sync_i   = sync;
        model_edge(en, load, per, sync);
        push_exp();
        @(posedge clk_in);
    endtask

    task automatic run(input int n, input logic [NUM_CH-1:0] en);
        for (int i = 0; i < n; i++) step(en, '0, 0, 1'b0);
    endtask

    // Reset pulsed between edges; the following edge runs with all channels enabled.
    task automatic async_reset_pulse();
        @(negedge clk_in);
        bus.en_i   = '1;
        bus.load_i = '0;
        bus.sync_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.tick_o !== '0) begin
            errors++;
            $display("FAIL async_reset_tick got=%b exp=%b", bus.tick_o, {NUM_CH{1'b0}});
        end
`ifdef TICK_SQUARE_EN
        checks++;
        if (bus.sq_o !== '0) begin
            errors++;
            $display("FAIL async_reset_sq got=%b exp=%b", bus.sq_o, {NUM_CH{1'b0}});
        end
`endif
        model_reset();
        #1 rst_n = 1'b1;
        model_edge('1, '0, 0, 1'b0);
        push_exp();
        @(posedge clk_in);
    endtask

    // Monitor: every edge that has a queued expectation is compared after settling.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            edge_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.tick_o !== e.tick) begin
                    errors++;
                    $display("FAIL tick edge=%0d got=%b exp=%b", edge_n, bus.tick_o, e.tick);
                end
`ifdef TICK_SQUARE_EN
                checks++;
                if (bus.sq_o !== e.sq) begin
                    errors++;
                    $display("FAIL sq edge=%0d got=%b exp=%b", edge_n, bus.sq_o, e.sq);
                end
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] en_r;
        logic [NUM_CH-1:0] ld_r;

        bus.en_i     = '0;
        bus.load_i   = '0;
        bus.period_i = '0;
        bus.sync_i   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (bus.tick_o !== '0) begin
            errors++;
            $display("FAIL reset_tick got=%b exp=%b", bus.tick_o, {NUM_CH{1'b0}});
        end
        rst_n = 1'b1;

        // Default period, then load period 3 on channel 1 at edge 7.
        run(6, '1);
        step('1, 2'b10, 3, 1'b0);
        run(10, '1);

        // Edge periods: 1, 0, and the largest representable value.
        step('1, '1, 1, 1'b0);
        run(5, '1);
        step('1, '1, 0, 1'b0);
        run(5, '1);
        step('1, 2'b01, (1 << CNT_W) - 1, 1'b0);
        run(262, '1);

        // Enable gap of 4 cycles once cnt reaches 2.
        step('1, '1, 5, 1'b0);
        run(2, '1);
        run(4, '0);
        run(10, '1);

        // Sync on the would-be tick edge, then sync together with a load.
        step('1, '1, 5, 1'b0);
        run(4, '1);
        step('1, '0, 0, 1'b1);
        run(12, '1);
        step('1, 2'b01, 3, 1'b1);
        run(8, '1);

        // Async reset while both channels tick every cycle.
        step('1, '1, 1, 1'b0);
        run(3, '1);
        async_reset_pulse();
        run(12, '1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                en_r[k] = ($urandom_range(0, 7) != 0);
                ld_r[k] = ($urandom_range(0, 39) == 0);
            end
            step(en_r, ld_r, int'($urandom_range(0, 9)), ($urandom_range(0, 59) == 0));
        end

        repeat (2) @(posedge clk_in);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
